cim_input_sequencer: RTL and testbench



---
 rtl/cim_pkg.sv | 27 ++
 rtl/cim_exp_max_tree.sv | 26 ++
 rtl/cim_input_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cim_input_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// cim_pkg: shared constants and types for the CIM input sequencer.
package cim_pkg;

  localparam int CIM_LANES = 36;
  localparam int LEN_INT   = 7;   // 4 digits + 3 zero drain cycles
  localparam int LEN_FP    = 11;  // 2 digits + 9 zero drain cycles

  // FP8 E5M2 lane layout; also reused as a plain 8-bit container in INT mode
  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [1:0] mant;
  } fp8_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALIGN  = 2'd1,
    S_STREAM = 2'd2,
    S_WAIT   = 2'd3
  } seq_state_t;

  // Terminal value of cnt for the given mode
  function automatic logic [3:0] stream_last(input logic fp);
    return fp ? 4'(LEN_FP - 1) : 4'(LEN_INT - 1);
  endfunction

endpackage

// File: rtl/cim_exp_max_tree.sv
// cim_exp_max_tree: combinational maximum of LANES 5-bit exponents,
// reduced pairwise over a power-of-two padded tree (pad leaves are 0).
module cim_exp_max_tree
  import cim_pkg::*;
#(
  parameter int LANES = CIM_LANES
) (
  input  logic [5*LANES-1:0] exp_vec,
  output logic [4:0]         exp_max
);

  localparam int P = 1 << $clog2(LANES);

  function automatic logic [4:0] tree_max(input logic [5*LANES-1:0] v);
    logic [4:0] node [2*P];
    for (int i = 0; i < 2*P; i++) node[i] = '0;
    for (int i = 0; i < LANES; i++) node[P+i] = v[5*i +: 5];
    for (int i = P-1; i >= 1; i--)
      node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
    return node[1];
  endfunction

  // Pure reduction, no state
  always_comb exp_max = tree_max(exp_vec);

endmodule

// File: rtl/cim_input_sequencer.sv
// cim_input_sequencer: accepts one activation vector, aligns FP8 exponents,
// streams 2-bit digits lane-parallel, then waits for CIM_done.
// Build option: define CIM_SEQ_FTZ_EN to flush FP8 subnormal lanes to zero.
// Handshake: a vector transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE and never depends
// on in_valid, and in_data/in_fp are only sampled on that transfer edge.
module cim_input_sequencer
  import cim_pkg::*;
#(
  parameter int LANES = CIM_LANES
) (
  input  logic               clk,
  input  logic               RSTN,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_fp,
  input  logic [8*LANES-1:0] in_data,
  input  logic               CIM_done,
  output logic               InFp,
  output logic               DataValid,
  output logic [3:0]         cnt,
  output logic [2*LANES-1:0] act_dig,
  output logic [LANES-1:0]   act_sign,
  output logic [LANES-1:0]   SDO,
  output logic [5*LANES-1:0] Diff,
  output logic [4:0]         exp_max,
  output logic               busy,
  output logic               seq_done
);

  seq_state_t             state_q, state_d;
  fp8_t [LANES-1:0]       lanes_q;
  logic [5*LANES-1:0]     tree_in;
  logic [4:0]             tree_max;
  logic [5*LANES-1:0]     diff_d;
  logic [LANES-1:0]       sdo_d, sign_d;
  logic [3:0]             last_cnt;

  assign last_cnt = stream_last(InFp);

  // State register
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus handshake and status outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    DataValid = 1'b0;
    busy      = 1'b1;
    seq_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = S_ALIGN;
      end
      S_ALIGN:  state_d = S_STREAM;
      S_STREAM: begin
        DataValid = 1'b1;
        if (cnt == last_cnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (CIM_done) begin
          seq_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Exponents fed to the max tree; INT mode and flushed lanes contribute 0
  always_comb begin
    tree_in = '0;
    if (InFp)
      for (int i = 0; i < LANES; i++) tree_in[5*i +: 5] = lanes_q[i].exp;
  end

  cim_exp_max_tree #(.LANES(LANES)) u_exp_max_tree (
    .exp_vec (tree_in),
    .exp_max (tree_max)
  );

  // Per-lane alignment values, registered at the end of ALIGN
  always_comb begin
    diff_d = '0;
    sdo_d  = '0;
    sign_d = '0;
    if (InFp) begin
      for (int i = 0; i < LANES; i++) begin
        sdo_d[i] = (lanes_q[i].exp != 5'd0);
`ifdef CIM_SEQ_FTZ_EN
        sign_d[i] = lanes_q[i].sign & (lanes_q[i].exp != 5'd0);
        if (lanes_q[i].exp != 5'd0)
          diff_d[5*i +: 5] = tree_max - lanes_q[i].exp;
`else
        sign_d[i] = lanes_q[i].sign;
        // Subnormals align as exponent 1; an all-zero vector keeps Diff at 0
        if (tree_max != 5'd0)
          diff_d[5*i +: 5] = tree_max -
                             ((lanes_q[i].exp == 5'd0) ? 5'd1 : lanes_q[i].exp);
`endif
      end
    end
  end

  // Operand capture, alignment registers and stream counter
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      lanes_q  <= '0;
      InFp     <= 1'b0;
      cnt      <= '0;
      exp_max  <= '0;
      Diff     <= '0;
      SDO      <= '0;
      act_sign <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        lanes_q <= in_data;
        InFp    <= in_fp;
      end
      if (state_q == S_ALIGN) begin
        exp_max  <= tree_max;
        Diff     <= diff_d;
        SDO      <= sdo_d;
        act_sign <= sign_d;
      end
      if (state_q == S_STREAM && cnt != last_cnt) cnt <= cnt + 4'd1;
      else                                        cnt <= '0;
    end
  end

  // Digit selection: MSB-first INT digits, or {0,hidden} then mantissa for FP
  always_comb begin
    act_dig = '0;
    if (state_q == S_STREAM) begin
      for (int i = 0; i < LANES; i++) begin
        if (!InFp) begin
          case (cnt)
            4'd0:    act_dig[2*i +: 2] = lanes_q[i][7:6];
            4'd1:    act_dig[2*i +: 2] = lanes_q[i][5:4];
            4'd2:    act_dig[2*i +: 2] = lanes_q[i][3:2];
            4'd3:    act_dig[2*i +: 2] = lanes_q[i][1:0];
            default: act_dig[2*i +: 2] = 2'b00;
          endcase
        end else if (cnt == 4'd0) begin
          act_dig[2*i +: 2] = {1'b0, SDO[i]};
        end else if (cnt == 4'd1) begin
`ifdef CIM_SEQ_FTZ_EN
          if (lanes_q[i].exp != 5'd0) act_dig[2*i +: 2] = lanes_q[i].mant;
`else
          act_dig[2*i +: 2] = lanes_q[i].mant;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cim_input_sequencer.sv
// tb_cim_input_sequencer: randomized scoreboard bench for cim_input_sequencer.
// Honours CIM_SEQ_FTZ_EN the same way the design does.
`timescale 1ns/1ps
module tb_cim_input_sequencer;
  import cim_pkg::*;

  localparam int L  = 36;
  localparam int BW = 5 + 2*L;   // {InFp, cnt, act_dig}
  localparam int AW = 6 + 7*L;   // {InFp, exp_max, Diff, SDO, act_sign}

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             RSTN;
  logic             in_valid, in_fp, CIM_done;
  logic [8*L-1:0]   in_data;
  logic             in_ready, InFp, DataValid, busy, seq_done;
  logic [3:0]       cnt;
  logic [2*L-1:0]   act_dig;
  logic [L-1:0]     act_sign, SDO;
  logic [5*L-1:0]   Diff;
  logic [4:0]       exp_max;

  always #5 clk = ~clk;

  cim_input_sequencer dut (
    .clk(clk), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready),
    .in_fp(in_fp), .in_data(in_data), .CIM_done(CIM_done), .InFp(InFp),
    .DataValid(DataValid), .cnt(cnt), .act_dig(act_dig), .act_sign(act_sign),
    .SDO(SDO), .Diff(Diff), .exp_max(exp_max), .busy(busy), .seq_done(seq_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  logic [AW-1:0] align_q[$];
  int            start_q[$];
  int            done_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            op_open = 0;
  int            last_done_cyc = -1;
  bit            resp_on = 1;
  int            resp_delay = 0;
  bit            dv_prev = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  task automatic push_expect(input logic fp, input logic [8*L-1:0] d, input int hs_cyc);
    int e[L];
    int emax, len, v;
    logic [5*L-1:0] diff_w;
    logic [L-1:0]   sdo_w, sgn_w;
    logic [2*L-1:0] dig;
    emax = 0; diff_w = '0; sdo_w = '0; sgn_w = '0;
    for (int i = 0; i < L; i++) e[i] = fp ? int'(d[8*i+2 +: 5]) : 0;
    for (int i = 0; i < L; i++) if (e[i] > emax) emax = e[i];
    if (fp) begin
      for (int i = 0; i < L; i++) begin
        sdo_w[i] = (e[i] != 0);
`ifdef CIM_SEQ_FTZ_EN
        sgn_w[i] = d[8*i+7] && (e[i] != 0);
        diff_w[5*i +: 5] = (e[i] == 0) ? 5'd0 : 5'(emax - e[i]);
`else
        sgn_w[i] = d[8*i+7];
        diff_w[5*i +: 5] = (emax == 0) ? 5'd0 : 5'(emax - ((e[i] == 0) ? 1 : e[i]));
`endif
      end
    end
    align_q.push_back({fp, 5'(emax), diff_w, sdo_w, sgn_w});
    len = fp ? 11 : 7;
    for (int k = 0; k < len; k++) begin
      dig = '0;
      for (int i = 0; i < L; i++) begin
        v = int'(d[8*i +: 8]);
        if (!fp && k < 4)       dig[2*i +: 2] = 2'((v >> (6 - 2*k)) & 3);
        else if (fp && k == 0)  dig[2*i +: 2] = {1'b0, sdo_w[i]};
`ifdef CIM_SEQ_FTZ_EN
        else if (fp && k == 1)  dig[2*i +: 2] = (e[i] == 0) ? 2'b00 : 2'(v & 3);
`else
        else if (fp && k == 1)  dig[2*i +: 2] = 2'(v & 3);
`endif
      end
      exp_q.push_back({fp, 4'(k), dig});
    end
    start_q.push_back(hs_cyc + 2);
  endtask

  // ---------------- monitor ----------------
  logic [BW-1:0] beat;
  always @(negedge clk) begin
    if (RSTN) begin
      check("in_ready", in_ready, !op_open);
      if (DataValid) begin
        if (exp_q.size() == 0) begin
          fail_now("beat_unexpected");
        end else begin
          beat = exp_q.pop_front();
          check("beat", {InFp, cnt, act_dig}, beat);
          if (beat[BW-2 -: 4] == 4'd0) begin
            if (align_q.size() > 0)
              check("align", {InFp, exp_max, Diff, SDO, act_sign}, align_q[0]);
            if (start_q.size() > 0) check("latency", cyc, start_q.pop_front());
          end
        end
      end else begin
        check("quiet_dig", {cnt, act_dig}, '0);
      end
      if (seq_done) begin
        if (done_q.size() == 0) begin
          fail_now("seq_done_unexpected");
        end else begin
          void'(done_q.pop_front());
          if (align_q.size() > 0)
            check("wait_hold", {InFp, exp_max, Diff, SDO, act_sign}, align_q.pop_front());
          last_done_cyc = cyc;
          op_open = 0;
        end
      end
    end
  end

  // ---------------- compute-side responder ----------------
  initial begin
    CIM_done = 1'b0;
    forever begin
      @(negedge clk);
      if (RSTN && resp_on && dv_prev && !DataValid) begin
        repeat (resp_delay) @(posedge clk);
        @(posedge clk); #1;
        CIM_done = 1'b1;
        done_q.push_back(1);
        @(posedge clk); #1;
        CIM_done = 1'b0;
      end
      dv_prev = DataValid;
    end
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic send_vec(input logic fp, input logic [8*L-1:0] d, input bit hold, output int hs_cyc);
    int  waited;
    bit  got;
    waited = 0; got = 0;
    in_fp = fp; in_data = d; in_valid = 1'b1;
    while (!got && waited < 300) begin
      @(negedge clk);
      if (in_ready) got = 1; else waited++;
    end
    hs_cyc = cyc;
    if (!got) begin
      fail_now("handshake_timeout");
      in_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      push_expect(fp, d, cyc);
      @(posedge clk); #1;
      op_open = 1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin @(posedge clk); n++; end while (op_open && n < budget);
    #1;
    if (op_open) begin
      fail_now("done_timeout");
      op_open = 0;
    end
  endtask

  task automatic wait_cnt(input logic [3:0] c);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(DataValid && cnt == c) && n < 50);
    if (!(DataValid && cnt == c)) fail_now("wait_cnt");
  endtask

  function automatic logic [8*L-1:0] rand_int_vec();
    logic [8*L-1:0] d;
    for (int i = 0; i < L; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  function automatic logic [8*L-1:0] rand_fp_vec(input int zero_pct);
    logic [8*L-1:0] d;
    logic [4:0] e;
    for (int i = 0; i < L; i++) begin
      e = ($urandom_range(0, 99) < zero_pct) ? 5'd0 : 5'($urandom_range(1, 31));
      d[8*i +: 8] = {1'($urandom_range(0, 1)), e, 2'($urandom_range(0, 3))};
    end
    return d;
  endfunction

  task automatic flush_sb();
    exp_q.delete(); align_q.delete(); start_q.delete(); done_q.delete();
    op_open = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [8*L-1:0] d;
  int hs, hs2, tdone;
  initial begin
    in_valid = 1'b0; in_fp = 1'b0; in_data = '0;
    RSTN = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_outs", {InFp, DataValid, cnt, act_dig, act_sign, SDO, Diff, exp_max, busy, seq_done}, '0);
    check("reset_in_ready", in_ready, 1'b1);
    RSTN = 1'b1;
    @(posedge clk); #1;

    // INT, all lanes 0xB4
    send_vec(1'b0, {L{8'hB4}}, 0, hs);
    wait_done(100);

    // FP with two normal lanes and subnormal remainder
    d = {L{8'h83}};
    d[7:0]  = {1'b0, 5'd20, 2'b01};
    d[15:8] = {1'b1, 5'd17, 2'b11};
    send_vec(1'b1, d, 0, hs);
    wait_done(100);

    // FP, every lane exponent 0
    send_vec(1'b1, {L{8'h82}}, 0, hs);
    wait_done(100);

    // randomized mix of modes and compute-side delays
    for (int n = 0; n < 24; n++) begin
      resp_delay = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) send_vec(1'b1, rand_fp_vec($urandom_range(0, 60)), 0, hs);
      else                           send_vec(1'b0, rand_int_vec(), 0, hs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      wait_done(100);
    end
    resp_delay = 1;

    // in_valid held through STREAM/WAIT; next vector lands the cycle after seq_done
    send_vec(1'b1, rand_fp_vec(20), 1, hs);
    send_vec(1'b0, rand_int_vec(), 0, hs2);
    check("held_accept_cycle", hs2, last_done_cyc + 1);
    wait_done(100);

    // CIM_done during STREAM and on the STREAM->WAIT edge is ignored
    resp_on = 0;
    send_vec(1'b0, rand_int_vec(), 0, hs);
    wait_cnt(4'd3);
    CIM_done = 1'b1;
    @(posedge clk); #1;
    CIM_done = 1'b0;
    wait_cnt(4'd6);
    CIM_done = 1'b1;
    @(posedge clk); #1;
    CIM_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    CIM_done = 1'b1;
    done_q.push_back(1);
    @(negedge clk);
    tdone = cyc;
    @(posedge clk); #1;
    CIM_done = 1'b0;
    check("wait_done_cycle", last_done_cyc, tdone);
    wait_done(20);

    // asynchronous reset mid-stream aborts without seq_done
    send_vec(1'b1, rand_fp_vec(30), 0, hs);
    wait_cnt(4'd5);
    #1;
    RSTN = 1'b0;
    #1;
    check("abort_outs", {InFp, DataValid, cnt, act_dig, act_sign, SDO, Diff, exp_max, busy, seq_done}, '0);
    check("abort_in_ready", in_ready, 1'b1);
    flush_sb();
    repeat (2) @(posedge clk); #1;
    RSTN = 1'b1;
    @(negedge clk);
    check("post_abort_in_ready", in_ready, 1'b1);
    repeat (6) @(posedge clk); #1;
    resp_on = 1;

    // recovery after abort
    send_vec(1'b1, rand_fp_vec(25), 0, hs);
    wait_done(100);
    send_vec(1'b0, rand_int_vec(), 0, hs);
    wait_done(100);

    repeat (4) @(posedge clk); #1;
    check("beats_left", exp_q.size(), 0);
    check("align_left", align_q.size(), 0);
    check("done_left", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
